// File: rtl/sd_dat_rx_crc16_pkg.sv
// Shared SD data-path definitions: CRC16-CCITT constants and
// receiver state encoding.
package sd_dat_rx_crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END,
    S_DONE,
    S_TIMEOUT
  } sd_rx_state_e;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        b
  );
    return {crc[14:0], 1'b0} ^
           ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_bit.sv
// One bit-serial CRC16-CCITT step; one instance per DAT line.
module sd_crc16_bit
  import sd_dat_rx_crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_step(crc_i, bit_i);

endmodule

// File: rtl/sd_dat_rx_crc16.sv
// SD 1-bit DAT block receiver: start detect, byte deserializer,
// CRC16 check, end-bit check and start timeout.
module sd_dat_rx_crc16
  import sd_dat_rx_crc16_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic        Sample,
  input  logic        DAT_In,
  output logic [7:0]  Data_Out,
  output logic        Data_Valid,
  output logic        Done,
  output logic        CRC_Ok,
  output logic        End_Err,
  output logic        Timeout,
  output logic [15:0] CRC_Calc,
  output logic [15:0] CRC_Rx
);

  localparam int unsigned NBITS = BLOCK_BYTES * 8;
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  sd_rx_state_e   state_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [3:0]     crc_cnt_q;
  logic [TW-1:0]  to_cnt_q;
  logic [7:0]     byte_q;
  logic           byte_rdy_q;
  logic [7:0]     data_out_q;
  logic           data_valid_q;
  logic           done_q;
  logic           crc_ok_q;
  logic           end_err_q;
  logic           timeout_q;
  logic [15:0]    crc_q;
  logic [15:0]    crc_d;
  logic [15:0]    crc_rx_q;

  sd_crc16_bit u_crc (
    .crc_i (crc_q),
    .bit_i (DAT_In),
    .crc_o (crc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_rdy_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      end_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      crc_q        <= CRC16_INIT;
      crc_rx_q     <= '0;
    end else if (!Enable) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_rdy_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      end_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      crc_q        <= CRC16_INIT;
      crc_rx_q     <= '0;
    end else begin
      // byte is published one edge after its last bit is sampled
      data_valid_q <= byte_rdy_q;
      byte_rdy_q   <= 1'b0;
      if (byte_rdy_q) data_out_q <= byte_q;
      unique case (state_q)
        S_IDLE: begin
          crc_q     <= CRC16_INIT;
          bit_cnt_q <= '0;
          crc_cnt_q <= '0;
          to_cnt_q  <= '0;
          state_q   <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (Sample) begin
            if (!DAT_In) begin
              state_q <= S_DATA;
            end else begin
              if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + TW'(1);
              if (to_cnt_q >= TO_LAST) begin
                state_q   <= S_TIMEOUT;
                timeout_q <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (Sample) begin
            crc_q  <= crc_d;
            byte_q <= {byte_q[6:0], DAT_In};
            if (bit_cnt_q[2:0] == 3'd7) byte_rdy_q <= 1'b1;
            if (bit_cnt_q == LAST_BIT) state_q <= S_CRC;
            else bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        S_CRC: begin
          if (Sample) begin
            crc_rx_q <= {crc_rx_q[14:0], DAT_In};
            if (crc_cnt_q == 4'd15) state_q <= S_END;
            else crc_cnt_q <= crc_cnt_q + 4'd1;
          end
        end
        S_END: begin
          if (Sample) begin
            end_err_q <= ~DAT_In;
            crc_ok_q  <= (crc_q == crc_rx_q);
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE, S_TIMEOUT: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Data_Out   = data_out_q;
  assign Data_Valid = data_valid_q;
  assign Done       = done_q;
  assign CRC_Ok     = crc_ok_q;
  assign End_Err    = end_err_q;
  assign Timeout    = timeout_q;
  assign CRC_Calc   = crc_q;
  assign CRC_Rx     = crc_rx_q;

endmodule

// File: tb/tb_sd_dat_rx_crc16.sv
// Directed bench for sd_dat_rx_crc16: 512-byte and 1-byte blocks,
// CRC/end-bit errors, start timeout, reset/abort, irregular strobes.
module tb_sd_dat_rx_crc16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_b = 1'b0;
  logic en_s = 1'b0;
  logic smp = 1'b0;
  logic dat = 1'b1;

  logic [7:0]  b_dout, s_dout;
  logic        b_dv, s_dv;
  logic        b_done, s_done;
  logic        b_ok, s_ok;
  logic        b_eerr, s_eerr;
  logic        b_to, s_to;
  logic [15:0] b_crc, s_crc;
  logic [15:0] b_rx, s_rx;

  int n_chk = 0;
  int n_pass = 0;
  int dv_cnt = 0;
  int dv_bad = 0;

  always #5 clk = ~clk;

  sd_dat_rx_crc16 #(
    .BLOCK_BYTES    (512),
    .TIMEOUT_CYCLES (16)
  ) u_big (
    .clk        (clk),
    .rst        (rst),
    .Enable     (en_b),
    .Sample     (smp),
    .DAT_In     (dat),
    .Data_Out   (b_dout),
    .Data_Valid (b_dv),
    .Done       (b_done),
    .CRC_Ok     (b_ok),
    .End_Err    (b_eerr),
    .Timeout    (b_to),
    .CRC_Calc   (b_crc),
    .CRC_Rx     (b_rx)
  );

  sd_dat_rx_crc16 #(
    .BLOCK_BYTES    (1),
    .TIMEOUT_CYCLES (16)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .Enable     (en_s),
    .Sample     (smp),
    .DAT_In     (dat),
    .Data_Out   (s_dout),
    .Data_Valid (s_dv),
    .Done       (s_done),
    .CRC_Ok     (s_ok),
    .End_Err    (s_eerr),
    .Timeout    (s_to),
    .CRC_Calc   (s_crc),
    .CRC_Rx     (s_rx)
  );

  always @(negedge clk) begin
    if (b_dv) begin
      dv_cnt++;
      if (b_dout != 8'hFF) dv_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int maxgap);
    dat = b;
    smp = 1'b1;
    tick();
    smp = 1'b0;
    dat = 1'b1;
    if (maxgap > 0) repeat ($urandom_range(1, maxgap)) tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    for (int i = 7; i >= 0; i--) strobe(v[i], maxgap);
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap);
    for (int i = 15; i >= 0; i--) strobe(w[i], maxgap);
  endtask

  task automatic big_block(input int maxgap);
    strobe(1'b0, maxgap);
    for (int n = 0; n < 512; n++) send_byte(8'hFF, maxgap);
    send_word(16'h7FA1, maxgap);
    strobe(1'b1, maxgap);
  endtask

  task automatic big_checks(input string tag);
    chk({tag, "_dv_cnt"}, dv_cnt, 512);
    chk({tag, "_dv_bad"}, dv_bad, 0);
    chk({tag, "_crc"}, b_crc, 16'h7FA1);
    chk({tag, "_rx"}, b_rx, 16'h7FA1);
    chk({tag, "_ok"}, b_ok, 1);
    chk({tag, "_eerr"}, b_eerr, 0);
    chk({tag, "_done"}, b_done, 1);
  endtask

  task automatic small_block(input logic [15:0] crc, input logic eb);
    en_s = 1'b1;
    tick();
    strobe(1'b0, 0);
    send_byte(8'h01, 0);
    send_word(crc, 0);
    strobe(eb, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_dout", b_dout, 0);
    chk("rst_dv", b_dv, 0);
    chk("rst_done", b_done, 0);
    chk("rst_ok", b_ok, 0);
    chk("rst_eerr", b_eerr, 0);
    chk("rst_to", b_to, 0);
    chk("rst_crc", b_crc, 0);
    chk("rst_rx", b_rx, 0);
    rst = 1'b0;
    tick();

    en_b = 1'b1;
    tick();
    dv_cnt = 0;
    dv_bad = 0;
    big_block(0);
    tick();
    big_checks("ff");
    en_b = 1'b0;
    tick();
    chk("ff_off_done", b_done, 0);
    chk("ff_off_crc", b_crc, 0);

    // strobe with DAT=0 on the enable-rise cycle must not start a block
    en_s = 1'b1;
    dat = 1'b0;
    smp = 1'b1;
    tick();
    smp = 1'b0;
    dat = 1'b1;
    strobe(1'b0, 0);
    send_byte(8'h01, 0);
    chk("b1_crc", s_crc, 16'h1021);
    chk("b1_dv_early", s_dv, 0);
    tick();
    chk("b1_dv", s_dv, 1);
    chk("b1_dout", s_dout, 8'h01);
    tick();
    chk("b1_dv_one", s_dv, 0);
    send_word(16'h1021, 0);
    chk("b1_done_early", s_done, 0);
    strobe(1'b1, 0);
    chk("b1_done", s_done, 1);
    chk("b1_ok", s_ok, 1);
    chk("b1_eerr", s_eerr, 0);
    chk("b1_rx", s_rx, 16'h1021);
    en_s = 1'b0;
    tick();

    small_block(16'h1020, 1'b1);
    chk("bad_done", s_done, 1);
    chk("bad_ok", s_ok, 0);
    chk("bad_rx", s_rx, 16'h1020);
    chk("bad_crc", s_crc, 16'h1021);
    en_s = 1'b0;
    tick();

    small_block(16'h1021, 1'b0);
    chk("eb0_done", s_done, 1);
    chk("eb0_eerr", s_eerr, 1);
    chk("eb0_ok", s_ok, 1);
    en_s = 1'b0;
    tick();

    en_s = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) strobe(1'b1, 0);
    chk("to_15", s_to, 0);
    strobe(1'b1, 0);
    chk("to_16", s_to, 1);
    chk("to_done", s_done, 0);
    strobe(1'b0, 0);
    chk("to_hold", s_to, 1);
    en_s = 1'b0;
    tick();
    chk("to_clr", s_to, 0);

    en_b = 1'b1;
    tick();
    strobe(1'b0, 0);
    for (int n = 0; n < 100; n++) send_byte(8'hFF, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    chk("pre_rst_dout", b_dout, 8'hFF);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", b_dout, 0);
    chk("mid_rst_crc", b_crc, 0);
    chk("mid_rst_done", b_done, 0);
    chk("mid_rst_dv", b_dv, 0);
    tick();
    rst = 1'b0;
    tick();
    dv_cnt = 0;
    dv_bad = 0;
    big_block(0);
    tick();
    big_checks("rerun");
    en_b = 1'b0;
    tick();

    en_b = 1'b1;
    tick();
    dv_cnt = 0;
    dv_bad = 0;
    big_block(5);
    tick();
    big_checks("irreg");
    en_b = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_dat_rx_crc16.md
# sd_dat_rx_crc16

Receive-side counterpart of the SD data-block CRC16 generator. It watches a single SD DAT line in 1-bit bus mode and detects the start bit. It deserializes `BLOCK_BYTES` data bytes MSB-first, computes CRC16-CCITT (poly 0x1021, init 0x0000) bit-serially, captures the 16 received CRC bits and checks the end bit. It sits between the SD clock/pin front-end and the read-data buffer, reporting per-byte data plus a block status.

## Interface
Parameters:
- `BLOCK_BYTES`, 512: data bytes per block (1..65535).
- `TIMEOUT_CYCLES`, 65535: sample strobes allowed in WAIT_START before `Timeout`.

Ports:
- `clk`  in  1  system clock. One clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `Enable`  in  1  level. High arms/runs the receiver; low returns it to IDLE synchronously and clears status.
- `Sample`  in  1  one-`clk` strobe marking a valid DAT sample (SD clock rising edge).
- `DAT_In`  in  1  DAT0 line, already synchronized.
- `Data_Out`  out  8  last completed byte.
- `Data_Valid`  out  1  one-cycle pulse per completed byte.
- `Done`  out  1  block finished; held until `Enable` low.
- `CRC_Ok`  out  1  `CRC_Calc == CRC_Rx`; meaningful while `Done`.
- `End_Err`  out  1  end bit sampled as 0; meaningful while `Done`.
- `Timeout`  out  1  no start bit within `TIMEOUT_CYCLES` strobes; held until `Enable` low.
- `CRC_Calc`  out  16  CRC computed over data bits.
- `CRC_Rx`  out  16  CRC bits received from line.

## Operation
- States: S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE, S_TIMEOUT.
- S_IDLE: when `Enable`=1, clear CRC/counters and go to S_WAIT_START.
- S_WAIT_START: on `Sample` with `DAT_In`=0, go to S_DATA. On `Sample` with `DAT_In`=1, increment the timeout counter. When the count reaches `TIMEOUT_CYCLES`, go to S_TIMEOUT and set `Timeout`=1.
- S_DATA: on each `Sample`, shift `DAT_In` into the byte register (MSB first) and update the CRC: crc <= {crc[14:0],0} ^ ((crc[15]^DAT_In) ? 0x1021 : 0).
  - After 8 bits, load `Data_Out` and pulse `Data_Valid`.
  - After `BLOCK_BYTES`×8 bits, go to S_CRC.
- S_CRC: shift 16 bits MSB-first into `CRC_Rx`; the CRC is frozen. After the 16th bit, go to S_END.
- S_END: on `Sample`, set `End_Err` = ~`DAT_In` and `CRC_Ok` = (`CRC_Calc`==`CRC_Rx`), then go to S_DONE with `Done`=1.
- S_DONE / S_TIMEOUT: hold all outputs. `Sample` is ignored.
- `Enable`=0 in any state: next edge goes to S_IDLE and clears all outputs and counters.
- Bit counter width: $clog2(BLOCK_BYTES*8+1). Byte/bit counters never wrap. The timeout counter saturates.

## Timing
- Reset values: `Data_Out`=0, `Data_Valid`=0, `Done`=0, `CRC_Ok`=0, `End_Err`=0, `Timeout`=0, `CRC_Calc`=0, `CRC_Rx`=0, state S_IDLE.
- `Data_Valid` is asserted on the `clk` edge after the edge that samples a byte's 8th bit, for exactly 1 cycle. `Data_Out` is stable from that edge until the next byte.
- `CRC_Calc` is updated on the same edge as each data sample.
- `Done`, `CRC_Ok` and `End_Err` are all valid on the edge after the end-bit sample.
- `Sample` is ignored on the cycle `Enable` rises (S_IDLE→S_WAIT_START transition).
- `rst` asserted mid-block: outputs go to reset values immediately, with no partial `Done`.
- `Enable` dropped mid-block: the block aborts, and no `Data_Valid` is emitted for a partial byte.
- `Sample` need not be periodic; bits are counted only on strobes.

## Structure
- A shared SD package holds the CRC16 polynomial constant (16'h1021), the CRC init value, and the state enum type.
- One natural sub-module: `sd_crc16_bit`. It is a combinational single-bit CRC16 step (crc_in, bit_in → crc_out), reusable by the 4-bit DAT variant (one instance per line).

## Test plan
- `BLOCK_BYTES`=512, 512×0xFF, CRC bits 0x7FA1, end bit 1 → 512 `Data_Valid` pulses all 0xFF, `CRC_Calc`=0x7FA1, `CRC_Ok`=1, `End_Err`=0, `Done`=1.
- `BLOCK_BYTES`=1, data 0x01, CRC 0x1021 → `Data_Out`=0x01, `CRC_Calc`=0x1021, `CRC_Ok`=1. Repeat with received CRC 0x1020 → `CRC_Ok`=0, `Done`=1.
- Valid block with end bit 0 → `Done`=1, `End_Err`=1, `CRC_Ok`=1.
- `TIMEOUT_CYCLES`=16, DAT held 1 for 16 strobes → `Timeout`=1 after the 16th strobe, `Done`=0. Drop `Enable` → `Timeout` clears next cycle.
- Assert `rst` after 100 data bytes → all outputs 0 immediately. Re-enable and send a full 0xFF block → `CRC_Calc`=0x7FA1.
- Irregular `Sample` spacing (1–5 idle cycles between strobes) on the 0xFF block → identical results to the regular-spacing case.
